// File: rtl/ins_cache_dm.sv
// Direct-mapped instruction cache between fetch and instruction memory.
// Misses fill a whole line via mem_req/mem_ack; flush walks the valid bits.
module ins_cache_dm #(
   parameter int ADDR_W = 32,
   parameter int LINES  = 4,
   parameter int WORDS  = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  cpu_req,
   input  logic [ADDR_W-1:0]     cpu_addr,
   output logic                  cpu_ready,
   output logic                  ohit,
   output logic [31:0]           oins,
   input  logic                  flush,
   output logic                  mem_req,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic                  mem_ack,
   input  logic [32*WORDS-1:0]   mem_data
);

   localparam int OFF_W = $clog2(WORDS) + 2;
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
   localparam int WB    = OFF_W - 2;

   typedef enum logic [1:0] {IDLE, MISS, FLUSH} state_t;

   state_t state, state_nx;

   logic [LINES-1:0]     valid;
   logic [TAG_W-1:0]     tag_q  [LINES];
   logic [32*WORDS-1:0]  data_q [LINES];
   logic [WB-1:0]        m_wrd;
   logic [IDX_W-1:0]     f_idx;
   logic                 pend;

   logic [TAG_W-1:0]     c_tag, m_tag;
   logic [IDX_W-1:0]     c_idx, m_idx;
   logic [WB-1:0]        c_wrd;
   logic                 hit;
   logic [31:0]          hit_word, fill_word;
   logic                 unused_bits;

   assign c_tag = cpu_addr[ADDR_W-1 -: TAG_W];
   assign c_idx = cpu_addr[OFF_W +: IDX_W];
   assign c_wrd = cpu_addr[2 +: WB];
   assign m_tag = mem_addr[ADDR_W-1 -: TAG_W];
   assign m_idx = mem_addr[OFF_W +: IDX_W];
   assign unused_bits = ^cpu_addr[1:0];

   assign hit       = valid[c_idx] && (tag_q[c_idx] == c_tag);
   assign cpu_ready = (state == IDLE);

   always_comb begin
      hit_word  = '0;
      fill_word = '0;
      for (int k = 0; k < WORDS; k++) begin
         if (c_wrd == k[WB-1:0])
            hit_word = data_q[c_idx][32*k +: 32];
         if (m_wrd == k[WB-1:0])
            fill_word = mem_data[32*k +: 32];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (flush)
               state_nx = FLUSH;
            else if (cpu_req && !hit)
               state_nx = MISS;
         end
         MISS: begin
            if (mem_ack)
               state_nx = (pend || flush) ? FLUSH : IDLE;
         end
         FLUSH: begin
            if (f_idx == IDX_W'(LINES-1))
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid    <= '0;
         ohit     <= 1'b0;
         oins     <= '0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         m_wrd    <= '0;
         f_idx    <= '0;
         pend     <= 1'b0;
      end else begin
         ohit <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!flush && cpu_req) begin
                  if (hit) begin
                     ohit <= 1'b1;
                     oins <= hit_word;
                  end else begin
                     mem_req  <= 1'b1;
                     mem_addr <= {cpu_addr[ADDR_W-1:OFF_W],
                                  {OFF_W{1'b0}}};
                     m_wrd    <= c_wrd;
                  end
               end
            end
            MISS: begin
               if (flush) pend <= 1'b1;
               // a flush seen on the ack cycle is folded into state_nx
               if (mem_ack) begin
                  valid[m_idx] <= 1'b1;
                  ohit         <= 1'b1;
                  oins         <= fill_word;
                  mem_req      <= 1'b0;
                  pend         <= 1'b0;
               end
            end
            FLUSH: begin
               valid[f_idx] <= 1'b0;
               f_idx        <= f_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == MISS && mem_ack) begin
         tag_q[m_idx]  <= m_tag;
         data_q[m_idx] <= mem_data;
      end
   end

endmodule

// File: tb/tb_ins_cache_dm.sv
// Bench for ins_cache_dm: cycle model of the cache contents plus
// directed scenarios with hand-computed literal expectations.
module tb_ins_cache_dm;

   logic         clk = 1'b0;
   logic         rstn = 1'b1;
   logic         cpu_req = 1'b0;
   logic [31:0]  cpu_addr = '0;
   logic         flush = 1'b0;
   logic         mem_ack = 1'b0;
   logic [127:0] mem_data = '0;
   logic         cpu_ready, ohit, mem_req;
   logic [31:0]  oins, mem_addr;

   ins_cache_dm #(.ADDR_W(32), .LINES(4), .WORDS(4)) dut (
      .clk(clk), .rstn(rstn),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr),
      .cpu_ready(cpu_ready), .ohit(ohit), .oins(oins),
      .flush(flush),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_data(mem_data)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] lw(input logic [31:0] a, input int k);
      if (a == 32'h100 && k == 1) return 32'hDEADBEEF;
      return 32'hA5000000 | (a << 4) | k;
   endfunction

   function automatic logic [127:0] line(input logic [31:0] a);
      logic [127:0] r;
      for (int k = 0; k < 4; k++) r[32*k +: 32] = lw(a, k);
      return r;
   endfunction

   // cache contents model: 4 lines of {valid, tag, 4 words}
   logic [3:0]  mv = '0;
   logic [31:0] mt [4];
   logic [31:0] md [4][4];
   logic        in_miss = 1'b0, pend = 1'b0;
   int          fl_left = 0;
   logic        e_ohit = 1'b0, e_req = 1'b0;
   logic [31:0] e_oins = '0, e_addr = '0;
   logic [1:0]  m_word = '0;
   logic [1:0]  c_ix, c_wd, m_ix;
   logic [31:0] c_tg;

   assign c_ix = cpu_addr[5:4];
   assign c_wd = cpu_addr[3:2];
   assign c_tg = cpu_addr >> 6;
   assign m_ix = e_addr[5:4];

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mv <= '0; in_miss <= 1'b0; pend <= 1'b0; fl_left <= 0;
         e_ohit <= 1'b0; e_req <= 1'b0; e_oins <= '0; e_addr <= '0;
      end else begin
         e_ohit <= 1'b0;
         if (fl_left > 0) begin
            mv[4-fl_left] <= 1'b0;
            fl_left <= fl_left - 1;
         end else if (in_miss) begin
            if (flush) pend <= 1'b1;
            if (mem_ack) begin
               mv[m_ix] <= 1'b1;
               mt[m_ix] <= e_addr >> 6;
               for (int k = 0; k < 4; k++)
                  md[m_ix][k] <= mem_data[32*k +: 32];
               e_oins  <= mem_data[32*m_word +: 32];
               e_ohit  <= 1'b1;
               e_req   <= 1'b0;
               in_miss <= 1'b0;
               pend    <= 1'b0;
               if (pend || flush) fl_left <= 4;
            end
         end else if (flush) begin
            fl_left <= 4;
         end else if (cpu_req) begin
            if (mv[c_ix] && mt[c_ix] == c_tg) begin
               e_ohit <= 1'b1;
               e_oins <= md[c_ix][c_wd];
            end else begin
               in_miss <= 1'b1;
               e_req   <= 1'b1;
               e_addr  <= {cpu_addr[31:4], 4'b0};
               m_word  <= c_wd;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("cpu_ready", cpu_ready, (!in_miss && fl_left == 0));
      check("ohit", ohit, e_ohit);
      check("oins", oins, e_oins);
      check("mem_req", mem_req, e_req);
      if (e_req) check("mem_addr", mem_addr, e_addr);
   end

   task automatic fetch(input logic [31:0] a, input int dly,
                        input int mode, output bit hit,
                        output logic [31:0] ins, output logic [31:0] la);
      cpu_req = 1'b1;
      cpu_addr = a;
      la = '0;
      @(negedge clk);
      cpu_req = 1'b0;
      hit = ohit;
      ins = oins;
      if (!hit) begin
         la = mem_addr;
         check("miss_req", mem_req, 1);
         for (int i = 0; i < dly; i++) begin
            flush = (mode == 2 && i == 0);
            if (mode == 1) begin
               cpu_req = i[0];
               cpu_addr = a + 32'h400 * (i + 1);
            end
            @(negedge clk);
            check("stall_addr", mem_addr, la);
            check("stall_req", mem_req, 1);
         end
         flush = 1'b0;
         cpu_req = 1'b0;
         mem_ack = 1'b1;
         mem_data = line(la);
         @(negedge clk);
         mem_ack = 1'b0;
         check("fill_ohit", ohit, 1);
         ins = oins;
      end
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (!cpu_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit h;
      logic [31:0] ins, la;
      int n;
      logic [31:0] alist [4];

      #1 rstn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", cpu_ready, 1);
      check("rst_ohit", ohit, 0);
      check("rst_oins", oins, 0);
      check("rst_req", mem_req, 0);
      check("rst_addr", mem_addr, 0);
      rstn = 1'b1;
      @(negedge clk);

      fetch(32'h104, 3, 0, h, ins, la);
      check("cold_hit", h, 0);
      check("cold_addr", la, 32'h100);
      check("cold_ins", ins, 32'hDEADBEEF);
      fetch(32'h10C, 0, 0, h, ins, la);
      check("warm_hit", h, 1);
      check("warm_ins", ins, 32'hA5001003);
      check("warm_noreq", mem_req, 0);

      cpu_req = 1'b1;
      n = 0;
      for (int k = 0; k < 4; k++) begin
         cpu_addr = 32'h100 + 4 * k;
         @(negedge clk);
         if (ohit) n++;
         check("burst_ins", oins, lw(32'h100, k));
      end
      cpu_req = 1'b0;
      check("burst_hits", n, 4);

      fetch(32'h140, 1, 0, h, ins, la);
      check("evict_hit", h, 0);
      check("evict_addr", la, 32'h140);
      fetch(32'h100, 0, 0, h, ins, la);
      check("reload_hit", h, 0);
      check("reload_addr", la, 32'h100);

      alist = '{32'h010, 32'h020, 32'h030, 32'h000};
      for (int i = 0; i < 3; i++) fetch(alist[i], 0, 0, h, ins, la);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      count_busy(n);
      check("flush_cycles", n, 4);
      alist = '{32'h100, 32'h010, 32'h020, 32'h030};
      for (int i = 0; i < 4; i++) begin
         fetch(alist[i], 1, 0, h, ins, la);
         check("post_flush_hit", h, 0);
      end

      fetch(32'h354, 2, 2, h, ins, la);
      check("fdm_hit", h, 0);
      check("fdm_addr", la, 32'h350);
      check("fdm_ins", ins, 32'hA5003501);
      count_busy(n);
      check("fdm_cycles", n, 4);
      fetch(32'h354, 0, 0, h, ins, la);
      check("fdm_rereq_hit", h, 0);

      fetch(32'h064, 10, 1, h, ins, la);
      check("stall_hit", h, 0);
      check("stall_la", la, 32'h060);
      check("stall_ins", ins, 32'hA5000601);
      fetch(32'h064, 0, 0, h, ins, la);
      check("stall_rehit", h, 1);
      check("stall_reins", ins, 32'hA5000601);

      cpu_req = 1'b1;
      cpu_addr = 32'h074;
      @(negedge clk);
      cpu_req = 1'b0;
      check("rm_req", mem_req, 1);
      #2 rstn = 1'b0;
      #1;
      check("rm_req0", mem_req, 0);
      check("rm_ohit0", ohit, 0);
      check("rm_oins0", oins, 0);
      check("rm_ready", cpu_ready, 1);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      mem_ack = 1'b1;
      mem_data = line(32'h070);
      @(negedge clk);
      mem_ack = 1'b0;
      check("stray_ohit", ohit, 0);
      check("stray_req", mem_req, 0);
      fetch(32'h064, 0, 0, h, ins, la);
      check("rm_old_hit", h, 0);
      fetch(32'h074, 0, 0, h, ins, la);
      check("rm_new_hit", h, 0);
      check("rm_new_ins", ins, 32'hA5000701);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
